exu_brupd_queue: RTL and testbench

- Branch-resolution update queue directly downstream of the EXU ALU control stage.
- Captures one resolved-branch packet per cycle from the ALU stage: predict_p_ff fields plus pc_ff.
- Buffers packets in a small FIFO and presents them to the IFU branch-predictor (BHT/BTB) update port with a valid/ready handshake.
- Decouples predictor-update timing from the EXU pipeline, so EXU never stalls on predictor write-port conflicts.

---
 rtl/exu_brupd_queue.sv | 120 ++++++++++++
 tb/tb_exu_brupd_queue.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/exu_brupd_queue.sv
`default_nettype none
// ============================================================================
//  Module      : exu_brupd_queue
//  Description : Branch-resolution update queue between the EXU ALU stage and
//                the IFU branch-predictor update port. Small FIFO with a
//                valid/ready drain, flush/clear handling and a saturating
//                counter of packets dropped while full.
//  Revision    : 1.0 - initial release
// ============================================================================
module exu_brupd_queue #(
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_flush,
    input  logic [30:0]              in_pc,
    input  logic                     in_misp,
    input  logic                     in_ataken,
    input  logic [1:0]               in_hist,
    input  logic                     in_way,
    input  logic                     in_boffset,
    input  logic                     clear,
    output logic                     upd_valid,
    input  logic                     upd_ready,
    output logic [30:0]              upd_pc,
    output logic                     upd_misp,
    output logic                     upd_ataken,
    output logic [1:0]               upd_hist,
    output logic                     upd_way,
    output logic                     upd_boffset,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic [CNTW-1:0]          drop_cnt
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam int c_EW = 37;

    // Packed entry layout: {pc[30:0], misp, ataken, hist[1:0], way, boffset}
    logic [c_EW-1:0] r_mem [DEPTH];
    logic [c_PW-1:0] r_rptr;
    logic [c_PW-1:0] r_wptr;
    logic [c_CW-1:0] r_count;
    logic [CNTW-1:0] r_drop_cnt;

    logic            w_enq_req;
    logic            w_deq;
    logic            w_full;
    logic            w_push;
    logic            w_drop;
    logic [c_EW-1:0] w_in_pkt;
    logic [c_EW-1:0] w_head;

    // Request qualification: clear overrides both sides of the handshake.
    always_comb begin
        w_full    = (r_count == c_CW'(DEPTH));
        w_enq_req = in_valid & ~in_flush & ~clear;
        w_deq     = (r_count != '0) & upd_ready & ~clear;
        // A full queue still accepts when the head leaves in the same cycle.
        w_push    = w_enq_req & (~w_full | w_deq);
        w_drop    = w_enq_req & w_full & ~w_deq;
        w_in_pkt  = {in_pc, in_misp, in_ataken, in_hist, in_way, in_boffset};
    end

    // Pointer, occupancy and drop-counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
        end else if (clear) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PW'(1);
            end
            if (w_deq) begin
                r_rptr <= r_rptr + c_PW'(1);
            end
            if (w_push && !w_deq) begin
                r_count <= r_count + c_CW'(1);
            end else if (!w_push && w_deq) begin
                r_count <= r_count - c_CW'(1);
            end
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + CNTW'(1);
            end
        end
    end

    // Entry storage; contents are qualified by occupancy so no reset is needed.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wptr] <= w_in_pkt;
        end
    end

    // Head presentation: flop mux, forced to zero while the queue is empty.
    always_comb begin
        w_head      = (r_count != '0) ? r_mem[r_rptr] : '0;
        upd_valid   = (r_count != '0);
        upd_pc      = w_head[36:6];
        upd_misp    = w_head[5];
        upd_ataken  = w_head[4];
        upd_hist    = w_head[3:2];
        upd_way     = w_head[1];
        upd_boffset = w_head[0];
        count       = r_count;
        full        = w_full;
        drop_cnt    = r_drop_cnt;
    end

endmodule
`default_nettype wire

// File: tb/tb_exu_brupd_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exu_brupd_queue
//  Description : Self-checking bench for exu_brupd_queue. A queue-based model
//                predicts every output; two DUT copies (8-bit and 2-bit drop
//                counters) share the stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exu_brupd_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_flush, in_misp, in_ataken, in_way, in_boffset;
    logic        clear, upd_ready;
    logic [30:0] in_pc;
    logic [1:0]  in_hist;

    logic        upd_valid, upd_misp, upd_ataken, upd_way, upd_boffset, full;
    logic [30:0] upd_pc;
    logic [1:0]  upd_hist;
    logic [2:0]  count;
    logic [7:0]  drop_cnt;

    logic        upd_valid2, upd_misp2, upd_ataken2, upd_way2, upd_boffset2, full2;
    logic [30:0] upd_pc2;
    logic [1:0]  upd_hist2;
    logic [2:0]  count2;
    logic [1:0]  drop_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [36:0] mq[$];
    int unsigned m_drops = 0;

    always #5 clk = ~clk;

    exu_brupd_queue #(.DEPTH(DEPTH), .CNTW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_flush(in_flush),
        .in_pc(in_pc), .in_misp(in_misp), .in_ataken(in_ataken),
        .in_hist(in_hist), .in_way(in_way), .in_boffset(in_boffset),
        .clear(clear), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_pc(upd_pc), .upd_misp(upd_misp), .upd_ataken(upd_ataken),
        .upd_hist(upd_hist), .upd_way(upd_way), .upd_boffset(upd_boffset),
        .count(count), .full(full), .drop_cnt(drop_cnt)
    );

    exu_brupd_queue #(.DEPTH(DEPTH), .CNTW(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_flush(in_flush),
        .in_pc(in_pc), .in_misp(in_misp), .in_ataken(in_ataken),
        .in_hist(in_hist), .in_way(in_way), .in_boffset(in_boffset),
        .clear(clear), .upd_valid(upd_valid2), .upd_ready(upd_ready),
        .upd_pc(upd_pc2), .upd_misp(upd_misp2), .upd_ataken(upd_ataken2),
        .upd_hist(upd_hist2), .upd_way(upd_way2), .upd_boffset(upd_boffset2),
        .count(count2), .full(full2), .drop_cnt(drop_cnt2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: a plain FIFO of packets, evaluated once per edge.
    task automatic model_edge();
        logic do_deq;
        logic do_enq;
        if (rst) begin
            mq.delete();
            m_drops = 0;
        end else if (clear) begin
            mq.delete();
        end else begin
            do_deq = (mq.size() != 0) && upd_ready;
            do_enq = in_valid && !in_flush;
            if (do_deq) void'(mq.pop_front());
            if (do_enq) begin
                if (mq.size() < DEPTH) mq.push_back({in_pc, in_misp, in_ataken, in_hist, in_way, in_boffset});
                else m_drops++;
            end
        end
    endtask

    task automatic check_all();
        logic [36:0] exp_head;
        exp_head = (mq.size() != 0) ? mq[0] : 37'd0;
        chk("upd_valid", 64'(upd_valid), 64'(mq.size() != 0));
        chk("upd_pkt", 64'({upd_pc, upd_misp, upd_ataken, upd_hist, upd_way, upd_boffset}), 64'(exp_head));
        chk("count", 64'(count), 64'(mq.size()));
        chk("full", 64'(full), 64'(mq.size() == DEPTH));
        chk("drop_cnt", 64'(drop_cnt), 64'((m_drops > 255) ? 255 : m_drops));
        chk("drop_cnt_sat2", 64'(drop_cnt2), 64'((m_drops > 3) ? 3 : m_drops));
        chk("count2", 64'(count2), 64'(mq.size()));
        chk("upd_pkt2", 64'({upd_pc2, upd_misp2, upd_ataken2, upd_hist2, upd_way2, upd_boffset2}), 64'(exp_head));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [30:0] pc);
        in_valid   = v;
        in_pc      = pc;
        in_misp    = pc[0];
        in_ataken  = pc[1];
        in_hist    = pc[3:2];
        in_way     = pc[1] ^ pc[0];
        in_boffset = ~pc[0];
    endtask

    initial begin
        logic        hold;
        logic [36:0] snap;

        rst = 1'b1; in_flush = 1'b0; clear = 1'b0; upd_ready = 1'b0;
        drive(1'b0, 31'd0);

        // Reset then idle
        step(); step();
        rst = 1'b0;
        step(); step();
        chk("idle_valid", 64'(upd_valid), 64'd0);

        // Single pass-through
        drive(1'b1, 31'h0000_0800);
        in_misp = 1'b1; in_ataken = 1'b1; in_hist = 2'b11; upd_ready = 1'b1;
        step();
        chk("pt_valid", 64'(upd_valid), 64'd1);
        chk("pt_pc", 64'(upd_pc), 64'h800);
        chk("pt_hist", 64'(upd_hist), 64'd3);
        drive(1'b0, 31'd0);
        step();
        chk("pt_empty", 64'(upd_valid), 64'd0);

        // Fill and drop
        upd_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 31'(i));
            step();
            if (i == 4) chk("fill_full", 64'(full), 64'd1);
        end
        chk("fill_drops", 64'(drop_cnt), 64'd2);
        drive(1'b0, 31'd0);
        upd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", 64'(upd_pc), 64'(i));
            step();
        end
        chk("drain_empty", 64'(upd_valid), 64'd0);

        // Full with simultaneous push/pop
        upd_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 31'(i));
            step();
        end
        drive(1'b1, 31'd5);
        upd_ready = 1'b1;
        step();
        chk("pp_count", 64'(count), 64'd4);
        chk("pp_drops", 64'(drop_cnt), 64'd2);
        drive(1'b0, 31'd0);
        for (int i = 2; i <= 5; i++) begin
            chk("pp_order", 64'(upd_pc), 64'(i));
            step();
        end

        // Flush and clear
        upd_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 31'(i + 16));
            step();
        end
        drive(1'b1, 31'd99);
        in_flush = 1'b1;
        step();
        chk("flush_count", 64'(count), 64'd3);
        in_flush = 1'b0;
        clear = 1'b1;
        step();
        chk("clear_count", 64'(count), 64'd0);
        chk("clear_valid", 64'(upd_valid), 64'd0);
        clear = 1'b0;

        // Saturation: three more drops take the total to five
        for (int i = 1; i <= 7; i++) begin
            drive(1'b1, 31'(i + 32));
            step();
        end
        chk("sat2", 64'(drop_cnt2), 64'd3);
        chk("sat8", 64'(drop_cnt), 64'd5);

        // Randomized backpressure with pointer wrap
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 3) != 0), 31'($urandom));
            in_flush  = ($urandom_range(0, 15) == 0);
            clear     = ($urandom_range(0, 39) == 0);
            upd_ready = $urandom_range(0, 1);
            hold = upd_valid && !upd_ready && !clear;
            snap = {upd_pc, upd_misp, upd_ataken, upd_hist, upd_way, upd_boffset};
            step();
            if (hold) chk("hold_stable", 64'({upd_pc, upd_misp, upd_ataken, upd_hist, upd_way, upd_boffset}), 64'(snap));
        end

        // Reset while entries are pending
        clear = 1'b0; in_flush = 1'b0; upd_ready = 1'b0;
        drive(1'b1, 31'h55);
        step(); step();
        rst = 1'b1; upd_ready = 1'b1;
        step();
        chk("rst_mid_valid", 64'(upd_valid), 64'd0);
        chk("rst_mid_drops", 64'(drop_cnt), 64'd0);
        rst = 1'b0;
        drive(1'b0, 31'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
